// File: rtl/fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetcher
//  Purpose  : Front-end fetch stage. Issues one memory request at a time,
//             statically predicts the next PC (JAL / backward branch taken),
//             buffers fetched words in a circular queue and hands one
//             instruction per cycle to issue when the target unit has room.
//  Revision : 1.0 - initial release
// ============================================================================
module fetcher #(
    parameter int IQ_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        has_misbranch,
    input  logic [31:0] correct_pc,
    input  logic        rob_avail,
    input  logic        rs_avail,
    input  logic        slb_avail,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_inst,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        can_issue,
    output logic        has_jump
);

    localparam int                 c_ptr_w = $clog2(IQ_DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(IQ_DEPTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_drop = 2'd2;

    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;

    logic [1:0]         r_state;
    logic [31:0]        r_fetch_pc;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_ptr_w:0]   r_count;

    logic [31:0]        r_q_inst [IQ_DEPTH];
    logic [31:0]        r_q_pc   [IQ_DEPTH];
    logic               r_q_jump [IQ_DEPTH];

    logic [6:0]  w_opcode;
    logic [31:0] w_j_imm;
    logic [31:0] w_b_imm;
    logic        w_is_jal;
    logic        w_pred_jump;
    logic [31:0] w_next_pc;
    logic [6:0]  w_head_op;
    logic        w_head_slb;
    logic        w_enq;
    logic        w_deq;

    // Decode the returning word just enough to predict the next fetch PC.
    assign w_opcode    = mem_inst[6:0];
    assign w_j_imm     = {{12{mem_inst[31]}}, mem_inst[19:12], mem_inst[20], mem_inst[30:21], 1'b0};
    assign w_b_imm     = {{20{mem_inst[31]}}, mem_inst[7], mem_inst[30:25], mem_inst[11:8], 1'b0};
    assign w_is_jal    = (w_opcode == c_op_jal);
    // Backward branches (sign bit set) are predicted taken; forward ones and JALR fall through.
    assign w_pred_jump = w_is_jal || ((w_opcode == c_op_branch) && mem_inst[31]);
    assign w_next_pc   = w_pred_jump ? (mem_addr + (w_is_jal ? w_j_imm : w_b_imm))
                                     : (mem_addr + 32'd4);

    // Loads and stores go to the SLBuffer, everything else to the RS.
    assign w_head_op  = r_q_inst[r_head][6:0];
    assign w_head_slb = (w_head_op == c_op_load) || (w_head_op == c_op_store);

    assign w_enq = rst && rdy && !has_misbranch && (r_state == c_st_wait) && mem_valid;
    assign w_deq = rdy && !has_misbranch && (r_count != '0) && rob_avail &&
                   (w_head_slb ? slb_avail : rs_avail);

    // Queue storage: written at the tail on every accepted response.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_inst[r_tail] <= mem_inst;
            r_q_pc[r_tail]   <= mem_addr;
            r_q_jump[r_tail] <= w_pred_jump;
        end
    end

    // Fetch FSM, queue pointers and registered issue outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_st_idle;
            r_fetch_pc <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            inst       <= '0;
            pc         <= '0;
            has_jump   <= 1'b0;
            can_issue  <= 1'b0;
        end else if (rdy) begin
            if (has_misbranch) begin
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                can_issue  <= 1'b0;
                r_fetch_pc <= correct_pc;
                // An outstanding request must still be retired by its response,
                // so keep mem_req up and swallow that response in DROP.
                if ((r_state != c_st_idle) && !mem_valid) begin
                    r_state <= c_st_drop;
                end else begin
                    r_state <= c_st_idle;
                    mem_req <= 1'b0;
                end
            end else begin
                if (w_deq) begin
                    inst      <= r_q_inst[r_head];
                    pc        <= r_q_pc[r_head];
                    has_jump  <= r_q_jump[r_head];
                    can_issue <= 1'b1;
                    r_head    <= r_head + 1'b1;
                end else begin
                    can_issue <= 1'b0;
                end

                if (w_enq) begin
                    r_tail <= r_tail + 1'b1;
                end

                if (w_enq && !w_deq) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_enq && w_deq) begin
                    r_count <= r_count - 1'b1;
                end

                case (r_state)
                    c_st_idle: begin
                        if (r_count < c_depth) begin
                            mem_req  <= 1'b1;
                            mem_addr <= r_fetch_pc;
                            r_state  <= c_st_wait;
                        end
                    end
                    c_st_wait: begin
                        if (mem_valid) begin
                            r_fetch_pc <= w_next_pc;
                            mem_req    <= 1'b0;
                            r_state    <= c_st_idle;
                        end
                    end
                    c_st_drop: begin
                        if (mem_valid) begin
                            mem_req <= 1'b0;
                            r_state <= c_st_idle;
                        end
                    end
                    default: begin
                        mem_req <= 1'b0;
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fetcher
//  Purpose  : Self-checking bench for fetcher. A transaction-level model
//             (instruction queue as an SV queue, predicted next PC taken from
//             the offset the generator chose) is advanced once per clock and
//             compared with the DUT on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetcher;

    localparam int c_depth = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        has_misbranch = 1'b0;
    logic [31:0] correct_pc = '0;
    logic        rob_avail = 1'b1;
    logic        rs_avail = 1'b1;
    logic        slb_avail = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_inst = '0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        can_issue;
    logic        has_jump;

    fetcher #(.IQ_DEPTH(c_depth)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .has_misbranch (has_misbranch),
        .correct_pc    (correct_pc),
        .rob_avail     (rob_avail),
        .rs_avail      (rs_avail),
        .slb_avail     (slb_avail),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_valid     (mem_valid),
        .mem_inst      (mem_inst),
        .inst          (inst),
        .pc            (pc),
        .can_issue     (can_issue),
        .has_jump      (has_jump)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        jump;
        logic        slb;
    } ent_t;

    typedef struct {
        int          kind;
        logic [31:0] off;
    } req_t;

    typedef enum int {M_IDLE, M_WAIT, M_DROP} mphase_t;

    ent_t        mq[$];
    req_t        forced[$];
    mphase_t     m_phase = M_IDLE;
    logic [31:0] m_fetch_pc = '0;
    logic        e_mem_req = 1'b0;
    logic [31:0] e_mem_addr = '0;
    logic [31:0] e_inst = '0;
    logic [31:0] e_pc = '0;
    logic        e_jump = 1'b0;
    logic        e_can = 1'b0;

    logic [31:0] resp_off = '0;
    logic        resp_jump = 1'b0;
    logic        resp_slb = 1'b0;
    int          lat = 1;
    int          max_kind = 0;
    bit          hold_mem = 1'b0;
    bit          tog = 1'b0;
    logic        prev_req = 1'b0;

    logic [31:0] seen_addr[$];
    logic [31:0] seen_pc[$];
    logic        seen_jump[$];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] c_seq_addr  [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    localparam logic [31:0] c_pred_addr [9] = '{32'h20, 32'h30, 32'h34, 32'h40, 32'h38,
                                                32'h3C, 32'h50, 32'h54, 32'h58};
    localparam logic [31:0] c_pred_pc   [8] = '{32'h20, 32'h30, 32'h34, 32'h40, 32'h38,
                                                32'h3C, 32'h50, 32'h54};
    localparam logic        c_pred_jmp  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // kind: 0 addi, 1 lw, 2 sw, 3 jal, 4 backward beq, 5 forward bne, 6 jalr, 7 lui
    task automatic make_inst(input int kind, input logic [31:0] off_in, input bit use_off,
                             output logic [31:0] w, output logic [31:0] off,
                             output logic jmp, output logic slb);
        logic [31:0] rnd;
        rnd = $urandom;
        off = off_in;
        jmp = 1'b0;
        slb = 1'b0;
        case (kind)
            0: w = {rnd[31:15], 3'b000, rnd[11:7], 7'b0010011};
            1: begin w = {rnd[31:15], 3'b010, rnd[11:7], 7'b0000011}; slb = 1'b1; end
            2: begin w = {rnd[31:15], 3'b010, rnd[11:7], 7'b0100011}; slb = 1'b1; end
            3: begin
                if (!use_off) off = {{11{rnd[20]}}, rnd[20:1], 1'b0};
                w = {off[20], off[10:1], off[11], off[19:12], rnd[11:7], 7'b1101111};
                jmp = 1'b1;
            end
            4: begin
                if (!use_off) off = -(32'(2 * $urandom_range(1, 2048)));
                w = {off[12], off[10:5], rnd[24:15], 3'b000, off[4:1], off[11], 7'b1100011};
                jmp = 1'b1;
            end
            5: begin
                if (!use_off) off = 32'(2 * $urandom_range(0, 2047));
                w = {off[12], off[10:5], rnd[24:15], 3'b001, off[4:1], off[11], 7'b1100011};
            end
            6: w = {rnd[31:15], 3'b000, rnd[11:7], 7'b1100111};
            default: w = {rnd[31:7], 7'b0110111};
        endcase
    endtask

    // One clock: memory responder drives mem_valid, the model takes the edge,
    // then DUT outputs are compared on the falling edge.
    task automatic tick();
        logic [31:0] w, off;
        logic        j, s;
        req_t        rq;
        ent_t        h;
        int          sz;
        mem_valid = 1'b0;
        if (!rst) begin
            tog       = ~tog;
            mem_valid = tog;
            mem_inst  = $urandom;
        end else if (rdy && e_mem_req && !hold_mem) begin
            if (lat == 0) begin
                if (m_phase != M_DROP && !has_misbranch && forced.size() > 0) begin
                    rq = forced.pop_front();
                    make_inst(rq.kind, rq.off, 1'b1, w, off, j, s);
                end else begin
                    make_inst(int'($urandom_range(0, max_kind)), 32'd0, 1'b0, w, off, j, s);
                end
                mem_valid = 1'b1;
                mem_inst  = w;
                resp_off  = off;
                resp_jump = j;
                resp_slb  = s;
                lat       = int'($urandom_range(0, 3));
            end else begin
                lat--;
            end
        end

        if (!rst) begin
            mq.delete();
            m_phase = M_IDLE; m_fetch_pc = '0; e_mem_req = 1'b0; e_mem_addr = '0;
            e_inst = '0; e_pc = '0; e_jump = 1'b0; e_can = 1'b0;
        end else if (rdy) begin
            if (has_misbranch) begin
                mq.delete();
                e_can      = 1'b0;
                m_fetch_pc = correct_pc;
                if (m_phase != M_IDLE && !mem_valid) begin
                    m_phase = M_DROP;
                end else begin
                    m_phase   = M_IDLE;
                    e_mem_req = 1'b0;
                end
            end else begin
                sz = mq.size();
                if (sz > 0 && rob_avail && (mq[0].slb ? slb_avail : rs_avail)) begin
                    h      = mq.pop_front();
                    e_inst = h.inst; e_pc = h.pc; e_jump = h.jump; e_can = 1'b1;
                end else begin
                    e_can = 1'b0;
                end
                case (m_phase)
                    M_IDLE: if (sz < c_depth) begin
                        e_mem_req = 1'b1; e_mem_addr = m_fetch_pc; m_phase = M_WAIT;
                    end
                    M_WAIT: if (mem_valid) begin
                        mq.push_back('{inst: mem_inst, pc: e_mem_addr, jump: resp_jump, slb: resp_slb});
                        m_fetch_pc = resp_jump ? e_mem_addr + resp_off : e_mem_addr + 32'd4;
                        e_mem_req  = 1'b0;
                        m_phase    = M_IDLE;
                    end
                    default: if (mem_valid) begin
                        e_mem_req = 1'b0; m_phase = M_IDLE;
                    end
                endcase
            end
        end

        @(negedge clk);
        check_eq("mem_req",   32'(mem_req),   32'(e_mem_req));
        check_eq("mem_addr",  mem_addr,       e_mem_addr);
        check_eq("can_issue", 32'(can_issue), 32'(e_can));
        check_eq("inst",      inst,           e_inst);
        check_eq("pc",        pc,             e_pc);
        check_eq("has_jump",  32'(has_jump),  32'(e_jump));

        if (mem_req && !prev_req) seen_addr.push_back(mem_addr);
        prev_req = mem_req;
        if (can_issue) begin
            seen_pc.push_back(pc);
            seen_jump.push_back(has_jump);
        end
    endtask

    task automatic clear_seen();
        seen_addr.delete();
        seen_pc.delete();
        seen_jump.delete();
    endtask

    initial begin
        // Reset with mem_valid toggling: nothing may be enqueued.
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        // Sequential addi fetch from address 0.
        max_kind = 0;
        clear_seen();
        for (int t = 0; t < 100 && (seen_addr.size() < 4 || seen_pc.size() < 3); t++) tick();
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("seq_addr%0d", i), (i < seen_addr.size()) ? seen_addr[i] : 32'hDEADBEEF, c_seq_addr[i]);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("seq_pc%0d", i), (i < seen_pc.size()) ? seen_pc[i] : 32'hDEADBEEF, c_seq_addr[i]);
            check_eq($sformatf("seq_jmp%0d", i), (i < seen_jump.size()) ? 32'(seen_jump[i]) : 32'hDEADBEEF, 32'd0);
        end

        // Static prediction: JAL, backward BEQ, forward BNE, JALR.
        has_misbranch = 1'b1; correct_pc = 32'h20;
        tick();
        has_misbranch = 1'b0;
        clear_seen();
        forced.push_back('{kind: 3, off: 32'h10});
        forced.push_back('{kind: 0, off: 32'h0});
        forced.push_back('{kind: 3, off: 32'hC});
        forced.push_back('{kind: 4, off: 32'hFFFFFFF8});
        forced.push_back('{kind: 0, off: 32'h0});
        forced.push_back('{kind: 3, off: 32'h14});
        forced.push_back('{kind: 5, off: 32'h20});
        forced.push_back('{kind: 6, off: 32'h0});
        for (int t = 0; t < 200 && (seen_addr.size() < 9 || seen_pc.size() < 8); t++) tick();
        for (int i = 0; i < 9; i++)
            check_eq($sformatf("pred_addr%0d", i), (i < seen_addr.size()) ? seen_addr[i] : 32'hDEADBEEF, c_pred_addr[i]);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("pred_pc%0d", i), (i < seen_pc.size()) ? seen_pc[i] : 32'hDEADBEEF, c_pred_pc[i]);
            check_eq($sformatf("pred_jmp%0d", i), (i < seen_jump.size()) ? 32'(seen_jump[i]) : 32'hDEADBEEF, 32'(c_pred_jmp[i]));
        end

        // Misbranch while a request is outstanding: stale response dropped.
        max_kind = 7;
        hold_mem = 1'b1;
        for (int t = 0; t < 20 && m_phase != M_WAIT; t++) tick();
        check_eq("mb_pre_req", 32'(mem_req), 32'd1);
        has_misbranch = 1'b1; correct_pc = 32'h100;
        tick();
        has_misbranch = 1'b0;
        hold_mem = 1'b0;
        check_eq("mb_can_issue", 32'(can_issue), 32'd0);
        check_eq("mb_req_held", 32'(mem_req), 32'd1);
        clear_seen();
        prev_req = mem_req;
        for (int t = 0; t < 60 && (seen_addr.size() < 1 || seen_pc.size() < 1); t++) tick();
        check_eq("mb_new_addr", (seen_addr.size() > 0) ? seen_addr[0] : 32'hDEADBEEF, 32'h100);
        check_eq("mb_first_pc", (seen_pc.size() > 0) ? seen_pc[0] : 32'hDEADBEEF, 32'h100);

        // Backpressure until full, lw at head blocked by SLB, then drain across wrap.
        max_kind = 1;
        has_misbranch = 1'b1; correct_pc = 32'h200; rob_avail = 1'b0;
        tick();
        has_misbranch = 1'b0;
        forced.push_back('{kind: 1, off: 32'h0});
        clear_seen();
        repeat (150) tick();
        check_eq("full_mem_req", 32'(mem_req), 32'd0);
        check_eq("full_no_issue", 32'(seen_pc.size()), 32'd0);
        rob_avail = 1'b1; slb_avail = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("slb_block", 32'(can_issue), 32'd0);
        end
        slb_avail = 1'b1;
        for (int t = 0; t < 400 && seen_pc.size() < 24; t++) tick();
        for (int i = 0; i < 24; i++)
            check_eq($sformatf("wrap_pc%0d", i), (i < seen_pc.size()) ? seen_pc[i] : 32'hDEADBEEF, 32'h200 + 32'(4 * i));

        // rdy low for four cycles mid-stream.
        max_kind = 7;
        repeat (12) tick();
        rdy = 1'b0;
        repeat (4) tick();
        rdy = 1'b1;
        repeat (20) tick();

        // Randomised traffic.
        for (int c = 0; c < 2000; c++) begin
            rob_avail     = ($urandom_range(0, 4) != 0);
            rs_avail      = ($urandom_range(0, 4) != 0);
            slb_avail     = ($urandom_range(0, 4) != 0);
            rdy           = ($urandom_range(0, 19) != 0);
            has_misbranch = ($urandom_range(0, 49) == 0);
            correct_pc    = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        has_misbranch = 1'b0;
        rdy = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
